// File: rtl/wb_result_stage.sv
// MEM/WB result stage: registers the four writeback candidates and the mux
// select in front of the 32-bit 4:1 writeback mux.
//
// ALU, MEM and PC+1 results complete one cycle after they are accepted.
// A multdiv op instead parks the stage in WAIT_MD until one of three things
// happens: md_ready arrives, the timeout expires, or a flush discards the op.
// Multdiv errors and timeouts turn into a forced write of MD_EXC_CODE to
// EXC_REG.
//
// Handshake: a transfer happens on a rising edge where in_valid=1 and
// in_ready=1. in_ready depends only on the registered state. While it is low,
// upstream keeps in_valid and its payload stable. md_ready is a single-cycle
// pulse, qualified by md_exception, and it only counts while in WAIT_MD.
module wb_result_stage #(
    parameter int unsigned MD_TIMEOUT  = 64,
    parameter logic [31:0] MD_EXC_CODE = 32'd4,
    parameter logic [4:0]  EXC_REG     = 5'd30
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_mem,
    input  logic [31:0] in_pc1,
    input  logic [4:0]  in_rd,
    input  logic        in_we,
    input  logic [31:0] md_result,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic [31:0] mdata0,
    output logic [31:0] mdata1,
    output logic [31:0] mdata2,
    output logic [31:0] mdata3,
    output logic [1:0]  sel,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic        wb_valid,
    output logic        stall
);

    localparam int unsigned CNT_W = $clog2(MD_TIMEOUT + 1);

    // Counter value during the last permitted WAIT_MD cycle. The counter is 0
    // in the first WAIT_MD cycle, so this allows exactly MD_TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    localparam logic [1:0] KIND_MD = 2'b11;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_MD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] md_cnt_next;

    // rd/we of the outstanding multdiv op, held until it completes
    logic [4:0]       md_rd;
    logic             md_we;

    // One-cycle decisions that drive the output registers
    logic             take_wb;    // accept a single-cycle op
    logic             take_md;    // accept a multdiv op and start waiting
    logic             md_done;    // multdiv result arrived cleanly
    logic             md_fault;   // multdiv error or timeout -> exception write

    // Ready comes straight from the registered state, so it never depends
    // combinationally on this cycle's inputs.
    assign in_ready = (state == IDLE);
    assign stall    = ~in_ready;

    // State and timeout counter registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // Next-state logic and completion decisions. Flush has the highest priority.
    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        take_wb     = 1'b0;
        take_md     = 1'b0;
        md_done     = 1'b0;
        md_fault    = 1'b0;

        if (flush) begin
            // Discard whatever is in flight. A late md_ready lands in IDLE
            // and is ignored there.
            state_next  = IDLE;
            md_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_kind == KIND_MD) begin
                            take_md     = 1'b1;
                            state_next  = WAIT_MD;
                            md_cnt_next = '0;
                        end else begin
                            take_wb = 1'b1;
                        end
                    end
                end
                WAIT_MD: begin
                    md_cnt_next = md_cnt + CNT_W'(1);
                    if (md_ready) begin
                        // A result arriving in the timeout cycle still wins.
                        state_next  = IDLE;
                        md_cnt_next = '0;
                        if (md_exception) begin
                            md_fault = 1'b1;
                        end else begin
                            md_done = 1'b1;
                        end
                    end else if (md_cnt == CNT_LAST) begin
                        state_next  = IDLE;
                        md_cnt_next = '0;
                        md_fault    = 1'b1;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    md_cnt_next = '0;
                end
            endcase
        end
    end

    // Latch destination info of an accepted multdiv op
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            md_rd <= '0;
            md_we <= 1'b0;
        end else if (take_md) begin
            md_rd <= in_rd;
            md_we <= in_we;
        end
    end

    // Output registers. wb_valid/wb_we pulse for one cycle per completion.
    // Data, select and rd hold their last values between completions.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mdata0   <= '0;
            mdata1   <= '0;
            mdata2   <= '0;
            mdata3   <= '0;
            sel      <= '0;
            wb_rd    <= '0;
            wb_we    <= 1'b0;
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;

            if (take_wb) begin
                mdata0   <= in_alu;
                mdata1   <= in_mem;
                mdata2   <= in_pc1;
                sel      <= in_kind;
                wb_rd    <= in_rd;
                wb_we    <= in_we & (in_rd != 5'd0);
                wb_valid <= 1'b1;
            end

            if (md_done) begin
                mdata3   <= md_result;
                sel      <= KIND_MD;
                wb_rd    <= md_rd;
                wb_we    <= md_we & (md_rd != 5'd0);
                wb_valid <= 1'b1;
            end

            if (md_fault) begin
                mdata3   <= MD_EXC_CODE;
                sel      <= KIND_MD;
                wb_rd    <= EXC_REG;
                wb_we    <= 1'b1;
                wb_valid <= 1'b1;
            end
        end
    end

endmodule
